// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA command/timing block.
package vga_pkg;

    // Command opcodes carried in cmd_byte[7:6].
    localparam logic [1:0] OP_MODE = 2'b00;
    localparam logic [1:0] OP_BG_R = 2'b01;
    localparam logic [1:0] OP_BG_G = 2'b10;
    localparam logic [1:0] OP_BG_B = 2'b11;

    // Display modes; code 3 is unused and renders black like MODE_BLACK.
    typedef enum logic [1:0] {
        MODE_GRADIENT = 2'd0,
        MODE_SOLID    = 2'd1,
        MODE_BLACK    = 2'd2
    } vga_mode_e;

    // FIFO reader states.
    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_STROBE = 2'd1,
        RD_GAP    = 2'd2
    } rd_state_e;

    // Total pixels per line.
    function automatic int h_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    // Total lines per frame.
    function automatic int v_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    // Larger of two integers, used to size shared counters.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_fifo_reader.sv
// Command FIFO reader: synchronises nef, drives the active-low read strobe
// with programmable low/high times and latches one byte per read.
module vga_fifo_reader
    import vga_pkg::*;
#(
    parameter int RD_PULSE_CLKS = 6,
    parameter int RD_GAP_CLKS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] disp_cmd_in,
    input  logic       nef_in,
    output logic       disp_cmd_rd,
    output logic       cmd_strobe,
    output logic [7:0] cmd_byte
);

    localparam int RD_CNT_W = $clog2(max2(RD_PULSE_CLKS, RD_GAP_CLKS)) + 1;
    localparam logic [RD_CNT_W-1:0] PULSE_LAST = RD_CNT_W'(RD_PULSE_CLKS - 1);
    localparam logic [RD_CNT_W-1:0] GAP_LAST   = RD_CNT_W'(RD_GAP_CLKS - 1);

    rd_state_e             state_q, state_d;
    logic [RD_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  nef_q;
    logic                  rd_q, rd_d;
    logic                  strobe_q, strobe_d;
    logic [7:0]            byte_q, byte_d;

    // Next-state and output logic for the read handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        strobe_d = 1'b0;
        byte_d   = byte_q;
        case (state_q)
            RD_IDLE: begin
                if (nef_q) begin
                    rd_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RD_STROBE;
                end
            end
            RD_STROBE: begin
                cnt_d = cnt_q + RD_CNT_W'(1);
                if (cnt_q == PULSE_LAST) begin
                    // Data is taken straight from the FIFO bus at the end of the low pulse.
                    byte_d   = disp_cmd_in;
                    strobe_d = 1'b1;
                    rd_d     = 1'b1;
                    cnt_d    = '0;
                    state_d  = RD_GAP;
                end
            end
            RD_GAP: begin
                cnt_d = cnt_q + RD_CNT_W'(1);
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = RD_IDLE;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // State, counter, strobe and nef synchroniser registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RD_IDLE;
            cnt_q    <= '0;
            nef_q    <= 1'b0;
            rd_q     <= 1'b1;
            strobe_q <= 1'b0;
            byte_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nef_q    <= nef_in;
            rd_q     <= rd_d;
            strobe_q <= strobe_d;
            byte_q   <= byte_d;
        end
    end

    assign disp_cmd_rd = rd_q;
    assign cmd_strobe  = strobe_q;
    assign cmd_byte    = byte_q;

endmodule

// File: rtl/vga_cmd_timing.sv
// Programmable VGA timing generator with command-driven mode/background
// registers that are double-buffered and take effect at frame wrap.
module vga_cmd_timing
    import vga_pkg::*;
#(
    parameter int PIX_DIV       = 4,
    parameter int H_VISIBLE     = 800,
    parameter int H_FP          = 40,
    parameter int H_SYNC        = 128,
    parameter int H_BP          = 88,
    parameter int V_VISIBLE     = 600,
    parameter int V_FP          = 1,
    parameter int V_SYNC        = 4,
    parameter int V_BP          = 23,
    parameter bit HSYNC_POL     = 1'b1,
    parameter bit VSYNC_POL     = 1'b1,
    parameter int CNT_W         = 12,
    parameter int COLOR_W       = 4,
    parameter int RD_PULSE_CLKS = 6,
    parameter int RD_GAP_CLKS   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         disp_cmd_in,
    input  logic               nef_in,
    output logic               disp_cmd_rd,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               cmd_strobe,
    output logic [7:0]         cmd_byte,
    output logic               frame_start
);

    localparam int H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam int TICK_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  H_VIS_END = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0]  V_VIS_END = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0]  HS_FIRST  = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0]  HS_LAST   = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0]  VS_FIRST  = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0]  VS_LAST   = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    // Channel index 0/1/2 = red/green/blue throughout.
    logic [TICK_W-1:0]           tick_q, tick_d;
    logic [CNT_W-1:0]            hcount_q, hcount_d;
    logic [CNT_W-1:0]            vcount_q, vcount_d;
    logic                        hsync_q, hsync_d;
    logic                        vsync_q, vsync_d;
    logic                        frame_start_q, frame_start_d;
    logic                        pix_en;
    logic                        frame_wrap;
    logic                        visible;
    logic [1:0]                  mode_pend_q, mode_pend_d;
    logic [1:0]                  mode_act_q, mode_act_d;
    logic [2:0][COLOR_W-1:0]     bg_pend_q, bg_pend_d;
    logic [2:0][COLOR_W-1:0]     bg_act_q, bg_act_d;
    logic [2:0][COLOR_W-1:0]     rgb_q, rgb_d;
    logic [2:0][COLOR_W-1:0]     grad;

    vga_fifo_reader #(
        .RD_PULSE_CLKS (RD_PULSE_CLKS),
        .RD_GAP_CLKS   (RD_GAP_CLKS)
    ) u_reader (
        .clk         (clk),
        .rst         (rst),
        .disp_cmd_in (disp_cmd_in),
        .nef_in      (nef_in),
        .disp_cmd_rd (disp_cmd_rd),
        .cmd_strobe  (cmd_strobe),
        .cmd_byte    (cmd_byte)
    );

    // Gradient pattern: coarse horizontal ramp gated by one vcount bit per channel.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_grad
            assign grad[gi] = hcount_q[COLOR_W+4:5] & {COLOR_W{vcount_q[8-gi]}};
        end
    endgenerate

    // Pixel divider, raster counters and syncs derived from the updated counts.
    always_comb begin
        pix_en     = (tick_q == '0);
        tick_d     = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
        hcount_d   = hcount_q;
        vcount_d   = vcount_q;
        frame_wrap = 1'b0;
        if (pix_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d   = '0;
                    frame_wrap = 1'b1;
                end else begin
                    vcount_d = vcount_q + CNT_W'(1);
                end
            end else begin
                hcount_d = hcount_q + CNT_W'(1);
            end
        end
        hsync_d       = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
        frame_start_d = frame_wrap;
    end

    // Command decode into pending registers; pending copies to active at frame wrap.
    always_comb begin
        mode_pend_d = mode_pend_q;
        bg_pend_d   = bg_pend_q;
        if (cmd_strobe) begin
            case (cmd_byte[7:6])
                OP_MODE: mode_pend_d  = cmd_byte[1:0];
                OP_BG_R: bg_pend_d[0] = cmd_byte[COLOR_W-1:0];
                OP_BG_G: bg_pend_d[1] = cmd_byte[COLOR_W-1:0];
                default: bg_pend_d[2] = cmd_byte[COLOR_W-1:0];
            endcase
        end
        // Active takes the old pending value, so a same-clock write waits a frame.
        mode_act_d = frame_wrap ? mode_pend_q : mode_act_q;
        bg_act_d   = frame_wrap ? bg_pend_q   : bg_act_q;
    end

    // Colour path from pre-increment counts, so it lags the counters by one pixel.
    always_comb begin
        visible = (hcount_q < H_VIS_END) && (vcount_q < V_VIS_END);
        rgb_d   = rgb_q;
        if (pix_en) begin
            rgb_d = '0;
            if (visible) begin
                case (mode_act_q)
                    MODE_GRADIENT: rgb_d = grad;
                    MODE_SOLID:    rgb_d = bg_act_q;
                    default:       rgb_d = '0;
                endcase
            end
        end
    end

    // All timing, shadow and colour state.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q        <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            frame_start_q <= 1'b0;
            mode_pend_q   <= '0;
            mode_act_q    <= '0;
            bg_pend_q     <= '0;
            bg_act_q      <= '0;
            rgb_q         <= '0;
        end else begin
            tick_q        <= tick_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            mode_pend_q   <= mode_pend_d;
            mode_act_q    <= mode_act_d;
            bg_pend_q     <= bg_pend_d;
            bg_act_q      <= bg_act_d;
            rgb_q         <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign red         = rgb_q[0];
    assign green       = rgb_q[1];
    assign blue        = rgb_q[2];

endmodule

// File: tb/tb_vga_cmd_timing.sv
// Directed bench: small raster (PIX_DIV=2, H 8/2/2/2 = 14 px, V 4/1/1/1 = 7 lines),
// so a line is 28 clocks and a frame 196 clocks. A second instance uses
// active-low syncs and shares all inputs.
module tb_vga_cmd_timing;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] disp_cmd_in;
    logic       nef_in;

    logic       disp_cmd_rd, hsync, vsync, cmd_strobe, frame_start;
    logic [3:0] red, green, blue;
    logic [7:0] cmd_byte;

    logic       n_disp_cmd_rd, n_hsync, n_vsync, n_cmd_strobe, n_frame_start;
    logic [3:0] n_red, n_green, n_blue;
    logic [7:0] n_cmd_byte;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    vga_cmd_timing #(
        .PIX_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(12), .COLOR_W(4),
        .RD_PULSE_CLKS(6), .RD_GAP_CLKS(2)
    ) dut (
        .clk(clk), .rst(rst), .disp_cmd_in(disp_cmd_in), .nef_in(nef_in),
        .disp_cmd_rd(disp_cmd_rd), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .cmd_strobe(cmd_strobe), .cmd_byte(cmd_byte), .frame_start(frame_start)
    );

    vga_cmd_timing #(
        .PIX_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(12), .COLOR_W(4),
        .RD_PULSE_CLKS(6), .RD_GAP_CLKS(2)
    ) dut_n (
        .clk(clk), .rst(rst), .disp_cmd_in(disp_cmd_in), .nef_in(nef_in),
        .disp_cmd_rd(n_disp_cmd_rd), .hsync(n_hsync), .vsync(n_vsync),
        .red(n_red), .green(n_green), .blue(n_blue),
        .cmd_strobe(n_cmd_strobe), .cmd_byte(n_cmd_byte), .frame_start(n_frame_start)
    );

    // Advance n clocks; sample point is 1 time unit after the rising edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Step until frame_start, returning the step count (or -1 on timeout).
    task automatic wait_frame(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            step();
            if (frame_start === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Push one byte through the FIFO handshake and check it is latched.
    task automatic send_cmd(input logic [7:0] b, input string tag);
        bit ok;
        disp_cmd_in = b;
        nef_in      = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (disp_cmd_rd === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " rd fall"}, 32'(ok), 32'd1);
        nef_in = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cmd_strobe === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " strobe"}, 32'(ok), 32'd1);
        check({tag, " byte"}, 32'(cmd_byte), 32'(b));
        $display("cmd %s: byte 0x%02h latched", tag, cmd_byte);
        step(4);
    endtask

    initial begin
        int  n, hs, hs1, vs, nhs, nvs, per, low, gap, leak, cnt_a, st;
        bit  ok;
        logic [3:0] r2, g2, b2;

        rst = 1'b1; nef_in = 1'b0; disp_cmd_in = 8'h00;
        step(3);

        // Reset state
        check("rst rd", 32'(disp_cmd_rd), 32'd1);
        check("rst hsync", 32'(hsync), 32'd0);
        check("rst vsync", 32'(vsync), 32'd0);
        check("rst red", 32'(red), 32'd0);
        check("rst green", 32'(green), 32'd0);
        check("rst blue", 32'(blue), 32'd0);
        check("rst strobe", 32'(cmd_strobe), 32'd0);
        check("rst byte", 32'(cmd_byte), 32'd0);
        check("rst frame_start", 32'(frame_start), 32'd0);
        check("rst n_hsync", 32'(n_hsync), 32'd1);
        check("rst n_vsync", 32'(n_vsync), 32'd1);
        $display("reset: rd=%0b hs=%0b vs=%0b n_hs=%0b n_vs=%0b", disp_cmd_rd, hsync, vsync, n_hsync, n_vsync);

        // Timing: last pixel (h=13,v=6) is the 98th pix_en edge -> 195th clock after release
        rst = 1'b0;
        wait_frame(400, n);
        check("first frame_start", 32'(n), 32'd195);
        hs = 0; hs1 = 0; vs = 0; nhs = 0; nvs = 0; per = 0;
        for (int i = 1; i <= 196; i++) begin
            step();
            if (hsync === 1'b1) hs++;
            if (i <= 28 && hsync === 1'b1) hs1++;
            if (vsync === 1'b1) vs++;
            if (n_hsync === 1'b0) nhs++;
            if (n_vsync === 1'b0) nvs++;
            if (frame_start === 1'b1 && per == 0) per = i;
        end
        check("frame period", 32'(per), 32'd196);
        check("hsync clocks/line", 32'(hs1), 32'd4);
        check("hsync clocks/frame", 32'(hs), 32'd28);
        check("vsync clocks/frame", 32'(vs), 32'd28);
        check("n_hsync low clocks", 32'(nhs), 32'd28);
        check("n_vsync low clocks", 32'(nvs), 32'd28);
        $display("timing: period=%0d hs=%0d vs=%0d nhs=%0d nvs=%0d", per, hs, vs, nhs, nvs);

        // Reader: 6 clocks low, strobe with 0x41, then 2 gap clocks + 1 idle clock high
        disp_cmd_in = 8'h41; nef_in = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (disp_cmd_rd === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("rd first fall", 32'(ok), 32'd1);
        low = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (disp_cmd_rd !== 1'b0) break;
            low++;
        end
        check("rd low clocks", 32'(low), 32'd6);
        check("strobe at rd rise", 32'(cmd_strobe), 32'd1);
        check("byte 0x41", 32'(cmd_byte), 32'h41);
        step();
        check("strobe one clock", 32'(cmd_strobe), 32'd0);
        gap = 2;
        for (int i = 0; i < 20; i++) begin
            step();
            if (disp_cmd_rd === 1'b0) break;
            gap++;
        end
        check("rd high gap", 32'(gap), 32'd3);
        $display("reader: low=%0d gap=%0d byte=0x%02h", low, gap, cmd_byte);
        nef_in = 1'b0;
        step(12);

        // Mid-frame writes stay hidden until the next frame_start
        wait_frame(400, n);
        check("sync to frame", 32'(n > 0), 32'd1);
        send_cmd(8'h01, "mode solid");
        send_cmd(8'h4A, "bg red");
        send_cmd(8'h85, "bg green");
        send_cmd(8'hC3, "bg blue");
        leak = 0; ok = 1'b0;
        for (int i = 0; i < 250; i++) begin
            step();
            if ({red, green, blue} !== 12'h000) leak++;
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame after writes", 32'(ok), 32'd1);
        check("no early colour", 32'(leak), 32'd0);
        // Pixel (0,0) shows 2 clocks after frame_start; 8 visible px x 2 clocks = 16 per line
        cnt_a = 0; r2 = '0; g2 = '0; b2 = '0;
        for (int i = 1; i <= 28; i++) begin
            step();
            if (i == 2) begin
                r2 = red; g2 = green; b2 = blue;
            end
            if (red === 4'hA) cnt_a++;
        end
        check("solid red", 32'(r2), 32'hA);
        check("solid green", 32'(g2), 32'h5);
        check("solid blue", 32'(b2), 32'h3);
        check("visible clocks/line", 32'(cnt_a), 32'd16);
        $display("solid: r=%0h g=%0h b=%0h vis_clks=%0d", r2, g2, b2, cnt_a);

        // Command latched on the frame_start clock (F+196) -> effective one frame later
        step(160);
        disp_cmd_in = 8'h02; nef_in = 1'b1;
        step(8);
        check("latch frame_start", 32'(frame_start), 32'd1);
        check("latch strobe", 32'(cmd_strobe), 32'd1);
        check("latch byte", 32'(cmd_byte), 32'h02);
        nef_in = 1'b0;
        step(2);
        check("old mode red", 32'(red), 32'hA);
        check("old mode green", 32'(green), 32'h5);
        step(194);
        check("next frame_start", 32'(frame_start), 32'd1);
        step(2);
        check("black red", 32'(red), 32'h0);
        check("black green", 32'(green), 32'h0);
        check("black blue", 32'(blue), 32'h0);
        $display("frame-edge write: rgb=%0h%0h%0h", red, green, blue);

        // Reset during the strobe pulse discards the byte
        disp_cmd_in = 8'h55; nef_in = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (disp_cmd_rd === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid rd fall", 32'(ok), 32'd1);
        step(2);
        check("mid rd still low", 32'(disp_cmd_rd), 32'd0);
        rst = 1'b1; nef_in = 1'b0;
        step();
        check("mid rst rd", 32'(disp_cmd_rd), 32'd1);
        check("mid rst strobe", 32'(cmd_strobe), 32'd0);
        check("mid rst hsync", 32'(hsync), 32'd0);
        check("mid rst red", 32'(red), 32'd0);
        step(2);
        rst = 1'b0;
        n = -1; st = 0; leak = 0;
        for (int i = 1; i <= 400; i++) begin
            step();
            if (cmd_strobe === 1'b1) st++;
            if ({red, green, blue} !== 12'h000) leak++;
            if (frame_start === 1'b1) begin
                n = i;
                break;
            end
        end
        check("post-rst frame_start", 32'(n), 32'd195);
        check("post-rst no strobe", 32'(st), 32'd0);
        check("post-rst colour", 32'(leak), 32'd0);
        $display("mid-read reset: frame after %0d clks, strobes=%0d", n, st);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
